sdram_req_queue: RTL

- Posted-write request queue between the FSMC peripheral-register logic (upstream) and sdram_controller (downstream).
- Upstream hands writes over in one cycle and is freed immediately; the queue then drains them to the controller with the adv/ack handshake.
- Reads are single-outstanding. A read issues only after every earlier write has completed, so read-after-write ordering holds.

---
 rtl/sdram_req_queue.sv | 200 ++++++++++++++++++++
 1 files changed

// File: rtl/sdram_req_queue.sv
// Posted-write queue in front of sdram_controller.
// Drains writes with adv/ack; a single read issues once writes are done.
module sdram_req_queue #(
  parameter int AW    = 27,
  parameter int DW    = 16,
  parameter int DEPTH = 8
) (
  input  logic                   i_clk,
  input  logic                   i_rst,
  input  logic                   i_wr_req,
  input  logic [AW-1:0]          i_wr_addr,
  input  logic [DW-1:0]          i_wr_data,
  output logic                   o_wr_full,
  output logic [$clog2(DEPTH):0] o_level,
  output logic                   o_overflow,
  input  logic                   i_rd_req,
  input  logic [AW-1:0]          i_rd_addr,
  output logic                   o_rd_busy,
  output logic                   o_rd_valid,
  output logic [DW-1:0]          o_rd_data,
  output logic                   o_busy,
  input  logic                   i_init_done,
  input  logic                   i_busy,
  input  logic                   i_ack,
  input  logic                   i_write_done,
  input  logic                   i_data_valid,
  input  logic [DW-1:0]          i_data,
  output logic                   o_adv,
  output logic                   o_rwn,
  output logic [AW-1:0]          o_addr,
  output logic [DW-1:0]          o_data
);

  localparam int PW = $clog2(DEPTH);
  localparam logic [PW:0]   CNT_FULL = (PW+1)'(DEPTH);
  localparam logic [PW:0]   CNT_ONE  = (PW+1)'(1);
  localparam logic [PW-1:0] PTR_ONE  = PW'(1);

  typedef enum logic [2:0] {
    IDLE,
    ISSUE_W,
    WAIT_W,
    ISSUE_R,
    WAIT_R
  } state_t;

  logic [AW-1:0] addr_mem [DEPTH];
  logic [DW-1:0] data_mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [PW:0]   count;
  logic          full;
  logic          empty;
  logic          push;
  logic          pop;

  logic          rd_pending;
  logic [AW-1:0] rd_addr_q;
  logic          rd_accept;
  logic          rd_done;

  state_t        state;
  state_t        state_n;
  logic          w_seen;
  logic          ready;
  logic          adv_n;
  logic          rwn_n;
  logic [AW-1:0] addr_n;
  logic [DW-1:0] data_n;
  logic          rd_valid_n;
  logic [DW-1:0] rd_data_n;

  assign full      = (count == CNT_FULL);
  assign empty     = (count == '0);
  assign push      = i_wr_req & ~full;
  assign ready     = i_init_done & ~i_busy;
  assign rd_accept = i_rd_req & ~rd_pending;

  assign o_wr_full = full;
  assign o_level   = count;
  assign o_rd_busy = rd_pending;
  assign o_busy    = ~empty | (state != IDLE) | rd_pending;

  always_ff @(posedge i_clk) begin
    if (push) begin
      addr_mem[wr_ptr] <= i_wr_addr;
      data_mem[wr_ptr] <= i_wr_data;
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      o_overflow <= 1'b0;
    end else begin
      if (push)
        wr_ptr <= wr_ptr + PTR_ONE;
      if (pop)
        rd_ptr <= rd_ptr + PTR_ONE;
      if (push & ~pop)
        count <= count + CNT_ONE;
      else if (pop & ~push)
        count <= count - CNT_ONE;
      if (i_wr_req & full)
        o_overflow <= 1'b1;
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      rd_pending <= 1'b0;
      rd_addr_q  <= '0;
    end else if (rd_done) begin
      rd_pending <= 1'b0;
    end else if (rd_accept) begin
      rd_pending <= 1'b1;
      rd_addr_q  <= i_rd_addr;
    end
  end

  always_comb begin
    state_n    = state;
    adv_n      = o_adv;
    rwn_n      = o_rwn;
    addr_n     = o_addr;
    data_n     = o_data;
    rd_valid_n = 1'b0;
    rd_data_n  = o_rd_data;
    pop        = 1'b0;
    rd_done    = 1'b0;
    unique case (state)
      IDLE: begin
        if (ready & ~empty) begin
          addr_n  = addr_mem[rd_ptr];
          data_n  = data_mem[rd_ptr];
          rwn_n   = 1'b0;
          adv_n   = 1'b1;
          state_n = ISSUE_W;
        end else if (ready & rd_pending) begin
          addr_n  = rd_addr_q;
          rwn_n   = 1'b1;
          adv_n   = 1'b1;
          state_n = ISSUE_R;
        end
      end
      ISSUE_W: begin
        if (i_ack) begin
          adv_n   = 1'b0;
          pop     = 1'b1;
          state_n = WAIT_W;
        end
      end
      WAIT_W: begin
        // fallback exit covers a write_done the controller never sent
        if (i_write_done | (ready & ~o_adv & w_seen))
          state_n = IDLE;
      end
      ISSUE_R: begin
        if (i_ack) begin
          adv_n   = 1'b0;
          state_n = WAIT_R;
        end
      end
      WAIT_R: begin
        if (i_data_valid) begin
          rd_data_n  = i_data;
          rd_valid_n = 1'b1;
          rd_done    = 1'b1;
          state_n    = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state      <= IDLE;
      w_seen     <= 1'b0;
      o_adv      <= 1'b0;
      o_rwn      <= 1'b1;
      o_addr     <= '0;
      o_data     <= '0;
      o_rd_valid <= 1'b0;
      o_rd_data  <= '0;
    end else begin
      state      <= state_n;
      w_seen     <= (state == WAIT_W);
      o_adv      <= adv_n;
      o_rwn      <= rwn_n;
      o_addr     <= addr_n;
      o_data     <= data_n;
      o_rd_valid <= rd_valid_n;
      o_rd_data  <= rd_data_n;
    end
  end

endmodule
